// File: rtl/residual_sad_accum.sv
// +----------------------------------------------------------------------------+
// | residual_sad_accum: per-row column SAD accumulation and best-match search.  |
// | Optional sequence checking with `define SAD_SEQ_CHECK_EN. Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module residual_sad_accum #(
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  output logic                                 ready,
  input  logic [31:0][7:0]                     residuals,
  input  logic [4:0]                           w_row_wr,
  input  logic [POI_DEPTH+POI_WIDTH-1:0]       POI_addr_wr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [4:0]                           best_row,
  output logic [4:0]                           best_col,
  output logic [8+POI_DEPTH+POI_WIDTH-1:0]     best_sad,
  output logic                                 seq_err
);

  localparam int ADDR_W = POI_DEPTH + POI_WIDTH;
  localparam int SAD_W  = 8 + ADDR_W;

  localparam logic [1:0] S_ACCUM   = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [SAD_W-1:0] r_acc [32];
  logic [4:0]       r_cur_row;
  logic [4:0]       r_scan;
  logic [4:0]       r_best_row;
  logic [4:0]       r_best_col;
  logic [SAD_W-1:0] r_best_sad;
  logic [31:0][7:0] w_abs;
  logic             w_take;
  logic             w_first_pix;
  logic             w_last_pix;
  logic             w_scan_end;
  logic             w_better;
  logic             w_handshake;

  // Negating 8'h80 yields 8'h80, which read unsigned is the required 128.
  always_comb begin
    w_abs = '0;
    for (int k = 0; k < 32; k++) begin
      w_abs[k] = residuals[k][7] ? (8'd0 - residuals[k]) : residuals[k];
    end
  end

  assign w_take      = en && ready;
  assign w_first_pix = (POI_addr_wr == '0);
  assign w_last_pix  = (POI_addr_wr == {ADDR_W{1'b1}});
  assign w_scan_end  = (r_scan == 5'd31);
  assign w_better    = (r_acc[r_scan] < r_best_sad);
  assign w_handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ACCUM:   if (w_take && w_last_pix) w_next_state = S_COMPARE;
      S_COMPARE: if (w_scan_end) w_next_state = (r_cur_row == 5'd31) ? S_DONE : S_ACCUM;
      S_DONE:    if (w_handshake) w_next_state = S_ACCUM;
      default:   w_next_state = S_ACCUM;
    endcase
  end

  always_comb begin
    ready     = (r_state == S_ACCUM);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) r_acc[k] <= '0;
      r_cur_row  <= '0;
      r_scan     <= '0;
      r_best_row <= '0;
      r_best_col <= '0;
      r_best_sad <= '1;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_take) begin
            for (int k = 0; k < 32; k++) begin
              r_acc[k] <= (w_first_pix ? '0 : r_acc[k]) + {{(SAD_W-8){1'b0}}, w_abs[k]};
            end
            r_cur_row <= w_row_wr;
            r_scan    <= '0;
          end
        end
        S_COMPARE: begin
          // Strict compare keeps the earliest candidate on ties.
          if (w_better) begin
            r_best_row <= r_cur_row;
            r_best_col <= r_scan;
            r_best_sad <= r_acc[r_scan];
          end
          r_scan <= r_scan + 5'd1;
        end
        S_DONE: begin
          if (w_handshake) begin
            r_best_row <= '0;
            r_best_col <= '0;
            r_best_sad <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign best_row = r_best_row;
  assign best_col = r_best_col;
  assign best_sad = r_best_sad;

`ifdef SAD_SEQ_CHECK_EN
  logic [ADDR_W-1:0] r_prev_addr;
  logic [4:0]        r_exp_row;
  logic              r_seq_err;
  logic              w_new_row;
  logic              w_addr_bad;
  logic              w_row_bad;

  // A previous address of all ones means the next beat opens a new row.
  assign w_new_row  = (r_prev_addr == {ADDR_W{1'b1}});
  assign w_addr_bad = (POI_addr_wr != ADDR_W'(r_prev_addr + 1'b1));
  assign w_row_bad  = w_new_row ? (w_row_wr != r_exp_row) : (w_row_wr != r_cur_row);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_addr <= '1;
      r_exp_row   <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_prev_addr <= POI_addr_wr;
        if (w_last_pix) r_exp_row <= w_row_wr + 5'd1;
        if (w_addr_bad || w_row_bad) r_seq_err <= 1'b1;
      end
      if (w_handshake) begin
        r_prev_addr <= '1;
        r_exp_row   <= '0;
      end
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/residual_sad_accum.md
# residual_sad_accum

Consumes the registered residual rows from the residual subtractor stage (32 signed 8-bit residuals per beat, tagged with window row and POI address) and reduces them to a single best-match result. For each window row, it accumulates a per-column sum of absolute differences (SAD) over every POI pixel, then scans the 32 column sums against a running minimum. After window row 31 it presents the winning (row, column, SAD) on a valid/ready output. It sits downstream of the subtractor and upstream of the stitching offset logic.

## Interface
- POI_DEPTH, 4, log2 of POI height in pixels
- POI_WIDTH, 4, log2 of POI width in pixels
- SAD_W (localparam), 8+POI_DEPTH+POI_WIDTH, accumulator and result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset), the only reset
- en  in  1  input beat valid
- ready  out  1  block accepts a beat this cycle; a beat is taken when en && ready
- residuals  in  8 x [31:0]  two's-complement residual per candidate column
- w_row_wr  in  5  window row of the beat
- POI_addr_wr  in  POI_DEPTH+POI_WIDTH  POI pixel index of the beat
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- best_row  out  5  winning window row
- best_col  out  5  winning column
- best_sad  out  SAD_W  winning SAD
- seq_err  out  1  sticky sequence error (see Configuration)

## Operation
- States: ACCUM, COMPARE, DONE. `ready` = (state == ACCUM).
- ACCUM, accepted beat:
  - abs(residuals[k]) = residuals[k] taken as signed 8-bit magnitude, so 8'h80 -> 128.
  - The magnitude is zero-extended to SAD_W.
  - If POI_addr_wr == 0: acc[k] <= abs. Otherwise: acc[k] <= acc[k] + abs.
  - w_row_wr is captured into cur_row on every beat.
  - If POI_addr_wr == all ones, the row is complete: move to COMPARE with scan index c = 0.
- COMPARE:
  - One column per cycle. If acc[c] < best_sad (strict), load best_row <= cur_row, best_col <= c, best_sad <= acc[c].
  - After c = 31: if cur_row == 31, go to DONE; otherwise go to ACCUM.
- DONE:
  - out_valid = 1. best_* are held stable until out_valid && out_ready.
  - On that handshake: best_sad <= all ones, best_row/best_col <= 0, state <= ACCUM.
- Tie-break: strict less-than keeps the earliest candidate (lowest row, then lowest column).
- No overflow is possible: 2^(POI_DEPTH+POI_WIDTH) x 128 < 2^SAD_W.
- Beats presented while ready == 0 are ignored. The upstream must hold them, because `en` gates the upstream pipeline.

## Timing
- Reset (reset == 0 at a clock edge):
  - state = ACCUM, so ready = 1.
  - out_valid = 0, best_row = 0, best_col = 0, best_sad = all ones.
  - acc[*] = 0, cur_row = 0, seq_err = 0.
- Reset mid-row or mid-scan abandons all partial sums and the running best. No output is produced for the aborted frame.
- A last-pixel beat accepted at edge E0:
  - Accumulators are updated at E0.
  - COMPARE runs on edges E1..E32 and ready is 0 during those cycles.
  - After E32, either ready = 1 (row < 31) or out_valid = 1 (row 31).
- Result latency from the final beat of row 31 to out_valid is 32 cycles.
- The out_ready handshake edge returns the block to ACCUM. ready is 1 on the following cycle.
- out_ready while out_valid == 0 is ignored.

## Configuration
- SAD_SEQ_CHECK_EN defined: seq_err is set (sticky until reset) when any of the following occurs:
  - an accepted beat's POI_addr_wr differs from the previous accepted POI_addr_wr + 1 (mod 2^(POI_DEPTH+POI_WIDTH));
  - w_row_wr changes within a row;
  - a new row's w_row_wr is not the previous row + 1 (row 0 expected after reset or after a result handshake).
- With SAD_SEQ_CHECK_EN defined, processing is otherwise unchanged.
- SAD_SEQ_CHECK_EN undefined: no check logic is built and seq_err is tied to 0.

## Test plan
Defaults apply (256 beats per row, 32 rows).
- All residuals 3, except row 5 column 7, which is 1 on every pixel -> best_row = 5, best_col = 7, best_sad = 256; out_valid 32 cycles after the last beat.
- All residuals 8'hFD (-3), except row 9 column 0, which is 8'h80 (-128) -> best_sad = 768 for row 0 column 0. A frame of all 8'h80 gives best_sad = 32768 with no wrap.
- All residuals equal -> best_row = 0, best_col = 0 (tie keeps earliest).
- Handshake and backpressure, in one frame:
  - en held high throughout COMPARE -> ready = 0 and no accumulator change.
  - out_ready held low 10 cycles -> out_valid and best_* stable; a frame started after the handshake reports independently.
- reset = 0 for 1 cycle at beat 100 of row 3, then a full clean frame -> result matches the clean-frame expectation only.
- SAD_SEQ_CHECK_EN defined:
  - Skip POI_addr_wr 17 in row 2 -> seq_err rises on the edge after the beat with address 18 and stays 1 until reset.
  - Clean frame -> seq_err stays 0.
